// File: rtl/irq_controller.sv
// Multi-source interrupt controller: synchronised edge capture, per-source pending/payload/overrun
// tracking, lowest-index priority, one interrupt held toward the CPU until acknowledged.
module irq_controller #(
    parameter int  NUM_SRC     = 4,
    parameter int  DATA_W      = 16,
    parameter int  ADDR_W      = 32,
    parameter int  SYNC_STAGES = 2,
    parameter int  VEC_SHIFT   = 2,
    localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        srcReq,
    input  logic [NUM_SRC*DATA_W-1:0] srcData,
    input  logic [NUM_SRC-1:0]        srcMask,
    input  logic [ADDR_W-1:0]         vecBase,
    input  logic                      globalEn,
    input  logic                      ack,
    input  logic [NUM_SRC-1:0]        ovrClr,
    output logic                      irq,
    output logic [DATA_W-1:0]         intData,
    output logic [ADDR_W-1:0]         intAddr,
    output logic [SRC_W-1:0]          intSrc,
    output logic [NUM_SRC-1:0]        pending,
    output logic [NUM_SRC-1:0]        overrun
);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] edge_det, hit, clr, load_buf, pending_d, overrun_d;
    logic [NUM_SRC-1:0] pending_q, overrun_q;
    logic [DATA_W-1:0]  payload_q [NUM_SRC];
    logic [SRC_W-1:0]   sel, int_src_q;
    logic [DATA_W-1:0]  int_data_q;
    logic [ADDR_W-1:0]  int_addr_q;
    logic               present_load;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= srcReq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        hit       = '0;
        clr       = '0;
        load_buf  = '0;
        pending_d = '0;
        overrun_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit[i]       = edge_det[i] & srcMask[i];
            // An edge landing on the ack of its own presented source re-arms it instead of overrunning.
            clr[i]       = (state_q == PRESENT) && ack && (int_src_q == SRC_W'(i));
            load_buf[i]  = hit[i] & (~pending_q[i] | clr[i]);
            pending_d[i] = (pending_q[i] & ~clr[i]) | hit[i];
            overrun_d[i] = (hit[i] & pending_q[i] & ~clr[i]) | (overrun_q[i] & ~ovrClr[i]);
        end
    end

    // NOTE: the payload buffers are reset as well, so nothing reads as X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) payload_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (load_buf[i]) payload_q[i] <= srcData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = SRC_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        present_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d      = PRESENT;
                    present_load = 1'b1;
                end
            end
            PRESENT: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            int_src_q  <= '0;
            int_data_q <= '0;
            int_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (present_load) begin
                int_src_q  <= sel;
                int_data_q <= payload_q[sel];
                int_addr_q <= vecBase + (ADDR_W'(sel) << VEC_SHIFT);
            end
        end
    end

    assign irq     = (state_q == PRESENT) & globalEn;
    assign intData = int_data_q;
    assign intAddr = int_addr_q;
    assign intSrc  = int_src_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios plus randomized traffic for irq_controller, checked against a
// cycle-level behavioural model of the edge/pending/presentation rules.
module tb_irq_controller;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  srcReq, srcMask, ovrClr, pending, overrun;
    logic [N*DW-1:0] srcData;
    logic [AW-1:0] vecBase, intAddr;
    logic          globalEn, ack, irq;
    logic [DW-1:0] intData;
    logic [1:0]    intSrc;

    int errors = 0;
    int checks = 0;

    irq_controller #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(S), .VEC_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .srcReq(srcReq), .srcData(srcData), .srcMask(srcMask),
        .vecBase(vecBase), .globalEn(globalEn), .ack(ack), .ovrClr(ovrClr),
        .irq(irq), .intData(intData), .intAddr(intAddr), .intSrc(intSrc),
        .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a rise seen S edges back on a request line is an event at this edge.
    logic [N-1:0]  m_hist [S+1];
    logic [N-1:0]  m_pend = '0;
    logic [N-1:0]  m_ovr  = '0;
    logic [DW-1:0] m_buf [N];
    bit            m_present = 1'b0;
    int            m_src = 0;
    logic [DW-1:0] m_data = '0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk or posedge rst) begin : model
        logic [N-1:0] rise;
        bit was_present, found, taking, fired, ovr_set;
        int was_src, pick;
        if (rst) begin
            for (int k = 0; k <= S; k++) m_hist[k] = '0;
            for (int i = 0; i < N; i++) m_buf[i] = '0;
            m_pend = '0; m_ovr = '0; m_present = 1'b0;
            m_src = 0; m_data = '0; m_addr = '0;
        end else begin
            rise = m_hist[S-1] & ~m_hist[S];
            was_present = m_present;
            was_src = m_src;
            if (!m_present) begin
                found = 1'b0;
                pick = 0;
                for (int i = 0; i < N; i++) if (m_pend[i] && !found) begin found = 1'b1; pick = i; end
                if (found) begin
                    m_present = 1'b1;
                    m_src = pick;
                    m_data = m_buf[pick];
                    m_addr = vecBase + 32'(pick * 4);
                end
            end else if (ack) begin
                m_present = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                taking  = was_present && ack && (was_src == i);
                fired   = rise[i] && srcMask[i];
                ovr_set = fired && m_pend[i] && !taking;
                if (fired && (!m_pend[i] || taking)) begin
                    m_pend[i] = 1'b1;
                    m_buf[i] = srcData[i*DW +: DW];
                end else if (taking) begin
                    m_pend[i] = 1'b0;
                end
                if (ovr_set) m_ovr[i] = 1'b1;
                else if (ovrClr[i]) m_ovr[i] = 1'b0;
            end
            for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = srcReq;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL reset_overrun: got %h want 0", overrun); end
        checks++; if (intData !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", intData); end
        checks++; if (intAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", intAddr); end
        checks++; if (intSrc !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", intSrc); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_idle_irq: got %b want 0", irq); end
    endtask

    task automatic test_single();
        srcData[2*DW +: DW] = 16'hBEEF;
        srcReq[2] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_early_irq: got %b want 0", irq); end
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b want 0100", pending); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b want 1", irq); end
        checks++; if (intData !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h want beef", intData); end
        checks++; if (intSrc !== 2'd2) begin errors++; $display("FAIL single_src: got %0d want 2", intSrc); end
        checks++; if (intAddr !== 32'h1008) begin errors++; $display("FAIL single_addr: got %h want 1008", intAddr); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_ack_irq: got %b want 0", irq); end
        checks++; if (pending !== 4'b0) begin errors++; $display("FAIL single_ack_pending: got %b want 0", pending); end
        srcReq[2] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_priority();
        srcData[1*DW +: DW] = 16'h1111;
        srcData[3*DW +: DW] = 16'h3333;
        srcReq[1] = 1'b1; srcReq[3] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (intSrc !== 2'd1 || irq !== 1'b1) begin errors++; $display("FAIL prio_first: got src %0d irq %b want src 1 irq 1", intSrc, irq); end
        checks++; if (intData !== 16'h1111) begin errors++; $display("FAIL prio_first_data: got %h want 1111", intData); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_gap: got irq %b want 0", irq); end
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_gap_pending: got %b want 1000", pending); end
        @(negedge clk);
        checks++; if (intSrc !== 2'd3 || irq !== 1'b1) begin errors++; $display("FAIL prio_second: got src %0d irq %b want src 3 irq 1", intSrc, irq); end
        checks++; if (intData !== 16'h3333 || intAddr !== 32'h100C) begin errors++; $display("FAIL prio_second_payload: got %h/%h want 3333/100c", intData, intAddr); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        srcReq[1] = 1'b0; srcReq[3] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pending !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL prio_drained: got pending %b irq %b want 0 0", pending, irq); end
    endtask

    task automatic test_overrun();
        srcData[0 +: DW] = 16'h1111;
        srcReq[0] = 1'b1;
        repeat (3) @(negedge clk);
        srcReq[0] = 1'b0;
        repeat (2) @(negedge clk);
        srcData[0 +: DW] = 16'h2222;
        srcReq[0] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (overrun !== 4'b0001) begin errors++; $display("FAIL ovr_flag: got %b want 0001", overrun); end
        checks++; if (intData !== 16'h1111 || irq !== 1'b1) begin errors++; $display("FAIL ovr_first_wins: got %h irq %b want 1111 irq 1", intData, irq); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL ovr_ack_pending: got %b want 0", pending[0]); end
        repeat (2) @(negedge clk);
        checks++; if (overrun[0] !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun[0]); end
        ovrClr[0] = 1'b1; @(negedge clk); ovrClr[0] = 1'b0;
        checks++; if (overrun !== 4'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        srcReq[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mask_enable();
        srcMask[2] = 1'b0;
        srcData[2*DW +: DW] = 16'h7777;
        srcReq[2] = 1'b1;
        repeat (2) @(negedge clk);
        srcReq[2] = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (pending !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL mask_discard: got pending %b irq %b want 0 0", pending, irq); end
        srcMask[2] = 1'b1;
        srcData[1*DW +: DW] = 16'h4242;
        srcReq[1] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b1 || intSrc !== 2'd1) begin errors++; $display("FAIL en_present: got irq %b src %0d want 1 1", irq, intSrc); end
        globalEn = 1'b0; #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL en_drop: got irq %b want 0", irq); end
        repeat (3) @(negedge clk);
        checks++; if (pending !== 4'b0010 || irq !== 1'b0) begin errors++; $display("FAIL en_hold: got pending %b irq %b want 0010 0", pending, irq); end
        srcMask[1] = 1'b0;
        @(negedge clk);
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL mask_keeps_pending: got %b want 0010", pending); end
        globalEn = 1'b1; #1;
        checks++; if (irq !== 1'b1 || intData !== 16'h4242) begin errors++; $display("FAIL en_restore: got irq %b data %h want 1 4242", irq, intData); end
        srcMask[1] = 1'b1;
        @(negedge clk);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        srcReq[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_collision();
        srcData[2*DW +: DW] = 16'hAAAA;
        srcReq[2] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b1 || intData !== 16'hAAAA) begin errors++; $display("FAIL coll_first: got irq %b data %h want 1 aaaa", irq, intData); end
        srcReq[2] = 1'b0;
        repeat (2) @(negedge clk);
        srcData[2*DW +: DW] = 16'h5555;
        srcReq[2] = 1'b1;
        repeat (2) @(negedge clk);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_gap: got irq %b want 0", irq); end
        checks++; if (pending[2] !== 1'b1 || overrun[2] !== 1'b0) begin errors++; $display("FAIL coll_flags: got pending %b overrun %b want 1 0", pending[2], overrun[2]); end
        @(negedge clk);
        checks++; if (irq !== 1'b1 || intData !== 16'h5555 || intSrc !== 2'd2) begin errors++; $display("FAIL coll_second: got irq %b data %h src %0d want 1 5555 2", irq, intData, intSrc); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        srcReq[2] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        srcData[3*DW +: DW] = 16'hCAFE;
        srcReq[3] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rmid_present: got irq %b want 1", irq); end
        #2 rst = 1'b1; #1;
        checks++; if (irq !== 1'b0 || pending !== 4'b0 || overrun !== 4'b0) begin errors++; $display("FAIL rmid_flags: got irq %b pending %b overrun %b want 0", irq, pending, overrun); end
        checks++; if (intData !== 16'h0 || intAddr !== 32'h0 || intSrc !== 2'd0) begin errors++; $display("FAIL rmid_regs: got %h %h %0d want 0 0 0", intData, intAddr, intSrc); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_idle: got irq %b want 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1 || intSrc !== 2'd3 || intData !== 16'hCAFE) begin errors++; $display("FAIL rmid_held_edge: got irq %b src %0d data %h want 1 3 cafe", irq, intSrc, intData); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b0 || pending !== 4'b0) begin errors++; $display("FAIL rmid_single_edge: got irq %b pending %b want 0 0", irq, pending); end
        srcReq[3] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if (irq !== (m_present & globalEn)) begin errors++; $display("FAIL rand_irq @%0d: got %b want %b", c, irq, m_present & globalEn); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending @%0d: got %b want %b", c, pending, m_pend); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun @%0d: got %b want %b", c, overrun, m_ovr); end
            checks++; if (intData !== m_data) begin errors++; $display("FAIL rand_data @%0d: got %h want %h", c, intData, m_data); end
            checks++; if (intSrc !== 2'(m_src)) begin errors++; $display("FAIL rand_src @%0d: got %0d want %0d", c, intSrc, m_src); end
            checks++; if (intAddr !== m_addr) begin errors++; $display("FAIL rand_addr @%0d: got %h want %h", c, intAddr, m_addr); end
            srcReq   = srcReq ^ (4'($urandom) & 4'($urandom));
            srcData  = {$urandom, $urandom};
            srcMask  = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
            globalEn = ($urandom_range(0, 7) != 0);
            ack      = ($urandom_range(0, 2) == 0);
            ovrClr   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 31) == 0) vecBase = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 : $urandom;
        end
        @(negedge clk);
        srcReq = '0; ack = 1'b0; ovrClr = '0; globalEn = 1'b1; srcMask = '1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        srcReq = '0; srcData = '0; srcMask = '1; vecBase = 32'h1000;
        globalEn = 1'b1; ack = 1'b0; ovrClr = '0;
        test_reset();
        test_single();
        test_priority();
        test_overrun();
        test_mask_enable();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
